// File: rtl/mem_bist_initiator.sv
// mem_bist_initiator: write/read-back memory self-test driving the data-memory client port; reports pass, error count and first failing address
module mem_bist_initiator #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [MEM_WIDTH-1:0]  seed,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [MEM_WIDTH-1:0]  data_write,
  output logic                  write_en,
  output logic                  read_en,
  input  logic [MEM_WIDTH-1:0]  data_read,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int LAST = READ_LATENCY - 1;
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  state_t state, nxt_state;
  logic [CW-1:0] i, nxt_i, n_q, nxt_n, n_clamp, nxt_err;
  logic [MEM_WIDTH-1:0] seed_q, nxt_seed;
  logic [ADDR_WIDTH-1:0] nxt_first;
  logic accept, mism, last_i;
  logic pv [READ_LATENCY];
  logic [MEM_WIDTH-1:0] pe [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] pa [READ_LATENCY];
  assign n_clamp = num_words > CW'(MEM_SIZE) ? CW'(MEM_SIZE) : num_words;
  assign accept = start && (state == IDLE || state == DONE);
  assign mism = pv[LAST] && data_read != pe[LAST];
  assign last_i = i == n_q - CW'(1);
  always_comb begin
    nxt_state = state;
    nxt_i = i;
    nxt_n = n_q;
    nxt_seed = seed_q;
    nxt_err = err_count;
    nxt_first = first_err_addr;
    if (mism) begin
      nxt_err = &err_count ? err_count : err_count + CW'(1);
      nxt_first = err_count == '0 ? pa[LAST] : first_err_addr;
    end
    if (accept) begin
      nxt_n = n_clamp;
      nxt_seed = seed;
      nxt_err = '0;
      nxt_first = '0;
      nxt_i = '0;
      nxt_state = n_clamp == '0 ? DONE : WRITE;
    end else begin
      case (state)
        WRITE: begin
          nxt_i = last_i ? '0 : i + CW'(1);
          nxt_state = last_i ? READ : WRITE;
        end
        READ: begin
          nxt_i = last_i ? '0 : i + CW'(1);
          nxt_state = last_i ? DRAIN : READ;
        end
        DRAIN: begin
          nxt_i = i == CW'(LAST) ? '0 : i + CW'(1);
          nxt_state = i == CW'(LAST) ? DONE : DRAIN;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      i <= '0;
      n_q <= '0;
      seed_q <= '0;
      addr <= '0;
      data_write <= '0;
      write_en <= 1'b0;
      read_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_err_addr <= '0;
    end else begin
      state <= nxt_state;
      i <= nxt_i;
      n_q <= nxt_n;
      seed_q <= nxt_seed;
      addr <= (nxt_state == WRITE || nxt_state == READ) ? nxt_i[ADDR_WIDTH-1:0] : '0;
      data_write <= nxt_state == WRITE ? nxt_seed + MEM_WIDTH'(nxt_i) : '0;
      write_en <= nxt_state == WRITE;
      read_en <= nxt_state == READ;
      busy <= nxt_state == WRITE || nxt_state == READ || nxt_state == DRAIN;
      done <= nxt_state == DONE;
      pass <= nxt_state == DONE && nxt_err == '0;
      err_count <= nxt_err;
      first_err_addr <= nxt_first;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        pv[k] <= 1'b0;
        pe[k] <= '0;
        pa[k] <= '0;
      end
    end else begin
      pv[0] <= read_en;
      pe[0] <= seed_q + MEM_WIDTH'(addr);
      pa[0] <= addr;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pv[k] <= pv[k-1];
        pe[k] <= pe[k-1];
        pa[k] <= pa[k-1];
      end
    end
endmodule

// File: doc/mem_bist_initiator.md
Name: mem_bist_initiator

Overview:
- Self-test initiator for the data-memory client port (addr / data_write / write_en / read_en / data_read).
- Walks a word range, writes a deterministic pattern, reads it back and compares.
- Pipelines reads and reports a pass/fail summary.
- Sits in place of the CPU-side client at bring-up. It drives the same port the core later uses, so the memory controller path is exercised without a processor.

Parameters:
- MEM_WIDTH, 32, data word width in bits.
- MEM_SIZE, 256, number of addressable words; the word count is clamped to this value.
- ADDR_WIDTH, 8, width of addr; must satisfy 2^ADDR_WIDTH >= MEM_SIZE.
- READ_LATENCY, 1, clock edges from the edge that registers a read to the edge at which data_read is valid; range 1..4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a test run.
- num_words  in  ADDR_WIDTH+1  number of words to test, starting at address 0.
- seed  in  MEM_WIDTH  pattern seed.
- addr  out  ADDR_WIDTH  memory word address.
- data_write  out  MEM_WIDTH  write data.
- write_en  out  1  write strobe, one word per cycle.
- read_en  out  1  read strobe, one word per cycle.
- data_read  in  MEM_WIDTH  read data from memory.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next accepted start.
- pass  out  1  valid while done is high; 1 means zero mismatches.
- err_count  out  ADDR_WIDTH+1  mismatch count; saturates at all-ones.
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch; 0 if none.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; expected-data pipeline cleared.
- FSM states:
  - IDLE / DONE -> WRITE: on start=1. Latch N = min(num_words, MEM_SIZE) and seed; clear err_count, first_err_addr, done, pass.
  - WRITE: one word per cycle. write_en=1, addr=i, data_write=seed+i (mod 2^MEM_WIDTH), read_en=0. After i=N-1, go to READ.
  - READ: one word per cycle. read_en=1, addr=i, write_en=0, data_write=0. Push expected value seed+i and address i into a READ_LATENCY-deep valid pipeline. After i=N-1, go to DRAIN.
  - DRAIN: no strobes. Stay READ_LATENCY cycles until the pipeline is empty, then go to DONE.
  - DONE: done=1, pass=(err_count==0), busy=0.
- Timing: start is sampled at edge E0; write cycles are 1..N; read cycles are N+1..2N; done first goes high in cycle 2N+READ_LATENCY+1.
- busy=1 in WRITE, READ and DRAIN only.
- write_en and read_en are never high in the same cycle.
- Compare rule:
  - The read issued in cycle t is compared against data_read at the edge ending cycle t+READ_LATENCY.
  - On mismatch, err_count increments (saturating).
  - On the first mismatch of a run, first_err_addr captures that read's address.
  - The comparison runs in both READ and DRAIN.
- Boundaries:
  - N=0: WRITE, READ and DRAIN are skipped; done=1, pass=1 one cycle after start.
  - num_words > MEM_SIZE: clamp to MEM_SIZE. The address never exceeds MEM_SIZE-1.
  - Pattern addition wraps modulo 2^MEM_WIDTH.
  - start while busy: ignored.
  - start in DONE: restarts a run.
  - start and reset high together: reset wins.
  - reset mid-run: strobes deassert immediately (asynchronous); memory contents are not restored.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then start with num_words=8, seed=1, model memory READ_LATENCY=1.
  - Writes 1..8 appear at addr 0..7 in cycles 1..8; reads at addr 0..7 in cycles 9..16.
  - done=1 at cycle 18, pass=1, err_count=0.
- Same run with the model corrupting address 5 (readback 0xDEAD):
  - err_count=1, first_err_addr=5, pass=0.
  - Corrupt addresses 3 and 6 instead -> err_count=2, first_err_addr=3.
- num_words=0 -> no strobes; done=1, pass=1 one cycle after start.
- num_words=300, MEM_SIZE=256 -> exactly 256 writes and 256 reads, max addr 255.
- seed=0xFFFFFFFE, num_words=4 -> data_write sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Timing checks:
  - READ_LATENCY=3, num_words=4 -> done at cycle 12 with pass=1.
  - Assert reset in cycle 5 of a run -> write_en=0, busy=0 in the same cycle.
  - Pulse start while busy -> the run length is unchanged.
